// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - radix-4 Booth sequential signed multiplier with one-hot FSM
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  input  logic                 active,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 suff
);

  localparam int AW = WIDTH + 2;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    LOAD  = 5'b00010,
    ADD   = 5'b00100,
    SHIFT = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        a_q, a_d;
  logic [AW-1:0]        m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [AW-1:0]        booth_op;
  logic                 booth_neg;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        shf_a;
  logic [WIDTH-1:0]     shf_q;
  logic                 shf_qm1;

  // Radix-4 recoding of {Q[1],Q[0],Q-1}; negation is inversion plus carry-in.
  always_comb begin
    booth_op  = '0;
    booth_neg = 1'b0;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: booth_op = m_q;
      3'b011:         booth_op = {m_q[AW-2:0], 1'b0};
      3'b100: begin
        booth_op  = {m_q[AW-2:0], 1'b0};
        booth_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        booth_op  = m_q;
        booth_neg = 1'b1;
      end
      default: booth_op = '0;
    endcase
    addend = booth_neg ? ~booth_op : booth_op;
  end

  // Arithmetic right shift of {A,Q,Q-1} by two.
  always_comb begin
    {shf_a, shf_q, shf_qm1} = {{2{a_q[AW-1]}}, a_q, q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (active) begin
          m_d     = {{2{X[WIDTH-1]}}, X};
          q_d     = Y;
          state_d = LOAD;
        end
      end
      LOAD: begin
        a_d     = '0;
        qm1_d   = 1'b0;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        a_d     = a_q + addend + AW'(booth_neg);
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d   = shf_a;
        q_d   = shf_q;
        qm1_d = shf_qm1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // Result is registered on entry to DONE so it is valid while suff is high.
          product_d = {shf_a[WIDTH-1:0], shf_q};
          state_d   = DONE;
        end else begin
          state_d = ADD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign suff    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - scoreboard bench for booth_multiplier with random and corner operands
module tb_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] X, Y;
  logic        active;
  logic [63:0] product;
  logic        busy, suff;

  booth_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .X(X), .Y(Y), .active(active),
    .product(product), .busy(busy), .suff(suff)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic prev_suff = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Monitor: pops one expectation per suff pulse, checks value and timing.
  always @(negedge clk) begin
    if (suff) begin
      check("suff_single_cycle", {63'd0, prev_suff}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_suff", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", product, e.prod);
        check("suff_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      check("suff_timeout", 64'(cyc), 64'(e.cyc));
    end
    prev_suff = suff;
  end

  // Drives one operation from IDLE, checks busy window and result hold.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] req);
    exp_t e;
    int   n;
    @(negedge clk);
    X = a; Y = b; active = 1'b1;
    n = cyc + 1;
    e.prod = req; e.cyc = n + 33;
    exp_q.push_back(e);
    @(negedge clk);
    active = 1'b0; X = $urandom; Y = $urandom;
    check("busy_load", {63'd0, busy}, 64'd1);
    repeat (33) @(negedge clk);
    check("busy_done", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("busy_idle", {63'd0, busy}, 64'd0);
    repeat (5) @(negedge clk);
    check("product_hold", product, req);
  endtask

  initial begin
    rst = 1'b1; active = 1'b0; X = '0; Y = '0;
    repeat (3) @(negedge clk);
    check("reset_product", product, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_suff", {63'd0, suff}, 64'd0);
    rst = 1'b0;

    run_op(32'd4802, 32'd172, 64'h00000000000C9A58);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);
    run_op(32'd0, 32'h12345678, 64'h0);
    run_op(32'h80000000, 32'h80000000, 64'h4000000000000000);
    run_op(32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000);

    // Abort: reset lands on edge N+10, then a new start right after release.
    @(negedge clk);
    X = 32'd1234; Y = 32'd5678; active = 1'b1;
    @(negedge clk);
    active = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_product", product, 64'd0);
    repeat (40) @(negedge clk);
    check("abort_no_result", product, 64'd0);
    run_op(32'hFFFFFFF6, 32'd3, 64'hFFFFFFFFFFFFFFE2);

    // Back-to-back with active held high; operands scrambled mid-run.
    begin
      logic [31:0] a, b;
      exp_t        e;
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        case (i % 100)
          0:       begin a = 32'h80000000; b = 32'h80000000; end
          1:       begin a = 32'h7FFFFFFF; b = 32'h7FFFFFFF; end
          2:       begin a = 32'h80000000; b = 32'h7FFFFFFF; end
          default: begin a = $urandom; b = $urandom; end
        endcase
        X = a; Y = b; active = 1'b1;
        e.prod = ref_mul(a, b);
        e.cyc  = cyc + 1 + 33;
        exp_q.push_back(e);
        repeat (5) @(negedge clk);
        X = $urandom; Y = $urandom;
        repeat (30) @(negedge clk);
      end
      active = 1'b0;
    end

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port X, input, 32, meaning the signed two's-complement multiplicand.
REQ-005 The block SHALL have port Y, input, 32, meaning the signed two's-complement multiplier.
REQ-006 The block SHALL have port active, input, 1, meaning the start request, sampled only in IDLE.
REQ-007 The block SHALL have port product, output, 64, meaning the signed product X*Y.
REQ-008 The block SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-009 The block SHALL have port suff, output, 1, meaning the done strobe: a single-cycle pulse when product is updated.

Function
REQ-010 The FSM SHALL be one-hot with five states: IDLE, LOAD, ADD, SHIFT, DONE.
REQ-011 IDLE SHALL go to LOAD on a clk edge with active=1, capturing M={X[31],X[31],X} (34 bits) and Q=Y; otherwise it SHALL stay in IDLE.
REQ-012 LOAD SHALL clear A (34 bits), Q-1 and the 4-bit iteration counter, then go to ADD.
REQ-013 ADD SHALL recode {Q[1],Q[0],Q-1} as follows: 000/111 gives +0; 001/010 gives +M; 011 gives +2M; 100 gives -2M; 101/110 gives -M.
REQ-014 ADD SHALL write A+sel into A, mod 2^34; subtraction SHALL use operand inversion plus carry-in=1, with no overflow flag.
REQ-015 SHIFT SHALL arithmetic-right-shift the 67-bit register {A,Q,Q-1} by 2, replicating A[33], and SHALL increment the counter.
REQ-016 SHIFT SHALL go to DONE when the counter was 15 before the increment; otherwise it SHALL go to ADD.
REQ-017 The block SHALL perform exactly 16 ADD/SHIFT pairs; counter wrap-around from 15 to 0 SHALL coincide with the exit to DONE.
REQ-018 DONE SHALL load product={A[31:0],Q[31:0]}, assert suff for that one cycle, then go to IDLE.
REQ-019 Latency: with active sampled at edge N, suff SHALL be high in the cycle after edge N+33, and busy SHALL be high from edge N to edge N+34.
REQ-020 product SHALL hold its value from DONE until the next DONE or until reset.
REQ-021 active SHALL be ignored outside IDLE; X and Y changes after the capture edge SHALL NOT affect the result.
REQ-022 With active held high continuously, the next operation SHALL be captured at edge N+35, one IDLE cycle after DONE.
REQ-023 The result SHALL be exact for all 2^64 operand pairs, including -2^31*-2^31 = 2^62 (no truncation, since A is 34 bits).
REQ-024 suff SHALL never be high for two consecutive cycles.

Reset
REQ-025 With rst=1 at a clk edge, the state SHALL become IDLE, A, Q, Q-1, M, the counter and product SHALL become 0, and suff and busy SHALL become 0.
REQ-026 rst SHALL take priority over active and over every FSM transition.
REQ-027 rst asserted mid-operation SHALL abort the operation: no suff pulse and product=0.
REQ-028 After rst is released, active=1 SHALL start a new operation on the first edge.

Verification
REQ-029 The bench SHALL drive X=4802, Y=172, active pulsed -> suff exactly 33 cycles after capture, product=64'h00000000000C9A58.
REQ-030 The bench SHALL drive X=-1, Y=-1 -> product=64'h0000000000000001; X=0, Y=32'h12345678 -> product=0.
REQ-031 The bench SHALL drive X=32'h80000000, Y=32'h80000000 -> product=64'h4000000000000000.
REQ-032 The bench SHALL drive X=32'h7FFFFFFF, Y=32'h80000000 -> product=64'hC000000080000000.
REQ-033 The bench SHALL assert rst at cycle 10 of an operation -> busy=0, product=0 on the next edge, and no suff until a new start.
REQ-034 The bench SHALL hold active high, change X/Y mid-run, and compare 1000 random pairs against a reference model -> every result matches its captured operands, with back-to-back starts 35 cycles apart.
